// File: rtl/uart_registers.sv
// 8N1 UART with TX/RX FIFOs behind a two-register bus window.
// DATA pushes TX / pops RX; STATUS holds flags, bits 2..3 are W1C.
module uart_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic [7:0] wdata_i,
  input  logic       pop_i,
  output logic [7:0] rdata_o,
  output logic       empty_o,
  output logic       full_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wp_q, wp_d;
  logic [AW:0] rp_q, rp_d;
  logic [7:0]  mem_q [DEPTH];
  logic        do_push, do_pop;

  assign empty_o = wp_q == rp_q;
  assign full_o  = (wp_q[AW] != rp_q[AW]) &&
                   (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  // a pop in the same cycle frees the slot for a push on a full fifo
  assign do_push = push_i && (!full_o || do_pop);
  assign wp_d    = wp_q + {{AW{1'b0}}, do_push};
  assign rp_d    = rp_q + {{AW{1'b0}}, do_pop};
  assign rdata_o = mem_q[rp_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q[AW-1:0]] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end
endmodule

module uart_registers #(
  parameter int         CLOCKS_PER_BIT = 434,
  parameter int         FIFO_DEPTH     = 8,
  parameter logic [6:0] BASE_INDEX     = 7'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [6:0]  register_index,
  input  logic        register_read,
  input  logic        register_write,
  input  logic [15:0] register_write_value,
  output logic [15:0] register_read_value,
  output logic        uart_tx,
  input  logic        uart_rx
);
  localparam int CW = $clog2(CLOCKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END  = CW'(CLOCKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLOCKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } state_e;

  logic hit_data, hit_stat;
  logic tx_push, tx_pop, tx_empty, tx_full;
  logic rx_push, rx_pop, rx_empty, rx_full;
  logic [7:0] tx_head, rx_head;
  logic clr_ovr, clr_ferr, set_ovr, set_ferr;
  logic ovr_q, ovr_d, ferr_q, ferr_d;
  logic [15:0] status, rd_q, rd_d;
  logic unused_wdata;

  assign hit_data = register_index == BASE_INDEX;
  assign hit_stat = register_index == BASE_INDEX + 7'd1;
  assign tx_push  = register_write && hit_data;
  assign rx_pop   = register_read && hit_data && !rx_empty;
  assign clr_ovr  = register_write && hit_stat && register_write_value[2];
  assign clr_ferr = register_write && hit_stat && register_write_value[3];
  assign unused_wdata = ^register_write_value[15:8];

  // ---------------- transmit ----------------
  state_e      tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic        tx_end;

  assign tx_end = tx_cnt_q == BIT_END;

  uart_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (tx_push),
    .wdata_i (register_write_value[7:0]),
    .pop_i   (tx_pop),
    .rdata_o (tx_head),
    .empty_o (tx_empty),
    .full_o  (tx_full)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    unique case (tx_state_q)
      S_IDLE: if (tx_pop) begin
        tx_state_d = S_START;
        tx_cnt_d   = '0;
        tx_sh_d    = tx_head;
      end
      S_START: if (tx_end) begin
        tx_state_d = S_DATA;
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
      end else tx_cnt_d = tx_cnt_q + CW'(1);
      S_DATA: if (tx_end) begin
        tx_cnt_d = '0;
        tx_sh_d  = {1'b0, tx_sh_q[7:1]};
        tx_bit_d = tx_bit_q + 3'd1;
        if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
      end else tx_cnt_d = tx_cnt_q + CW'(1);
      S_STOP: if (tx_end) begin
        tx_cnt_d   = '0;
        tx_state_d = tx_pop ? S_START : S_IDLE;
        if (tx_pop) tx_sh_d = tx_head;
      end else tx_cnt_d = tx_cnt_q + CW'(1);
    endcase
  end

  always_comb begin
    uart_tx = 1'b1;
    tx_pop  = 1'b0;
    unique case (tx_state_q)
      S_IDLE:  tx_pop  = !tx_empty;
      S_START: uart_tx = 1'b0;
      S_DATA:  uart_tx = tx_sh_q[0];
      S_STOP:  tx_pop  = tx_end && !tx_empty;
    endcase
  end

  // ---------------- receive ----------------
  logic [1:0]  sync_q;
  logic        rx_prev_q, rx_s, rx_smp;
  state_e      rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic        rx_brk_q, rx_brk_d;
  logic        rx_end;

  assign rx_s   = sync_q[1];
  assign rx_end = rx_cnt_q == BIT_END;

  uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (rx_push),
    .wdata_i (rx_sh_q),
    .pop_i   (rx_pop),
    .rdata_o (rx_head),
    .empty_o (rx_empty),
    .full_o  (rx_full)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= 2'b11;
      rx_prev_q  <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_brk_q   <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], uart_rx};
      rx_prev_q  <= rx_s;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_brk_q   <= rx_brk_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_brk_d   = rx_brk_q;
    unique case (rx_state_q)
      S_IDLE: if (rx_prev_q && !rx_s) begin
        rx_state_d = S_START;
        rx_cnt_d   = '0;
      end
      S_START: if (rx_cnt_q == HALF_END) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s ? S_IDLE : S_DATA;
      end else rx_cnt_d = rx_cnt_q + CW'(1);
      S_DATA: if (rx_end) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rx_s, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
      end else rx_cnt_d = rx_cnt_q + CW'(1);
      // after a bad stop bit, wait out the break before rearming
      S_STOP: if (rx_brk_q) begin
        if (rx_s) begin
          rx_state_d = S_IDLE;
          rx_brk_d   = 1'b0;
        end
      end else if (rx_end) begin
        rx_cnt_d = '0;
        if (rx_s) rx_state_d = S_IDLE;
        else rx_brk_d = 1'b1;
      end else rx_cnt_d = rx_cnt_q + CW'(1);
    endcase
  end

  always_comb begin
    rx_smp   = (rx_state_q == S_STOP) && !rx_brk_q && rx_end;
    rx_push  = rx_smp && rx_s;
    set_ovr  = rx_push && rx_full && !rx_pop;
    set_ferr = rx_smp && !rx_s;
  end

  // ---------------- registers ----------------
  assign ovr_d  = set_ovr || (ovr_q && !clr_ovr);
  assign ferr_d = set_ferr || (ferr_q && !clr_ferr);
  assign status = {11'h0, (tx_state_q != S_IDLE) || !tx_empty,
                   ferr_q, ovr_q, !tx_full, !rx_empty};

  always_comb begin
    rd_d = rd_q;
    if (register_read) begin
      rd_d = '0;
      unique case (1'b1)
        hit_data: rd_d = {8'h0, rx_empty ? 8'h0 : rx_head};
        hit_stat: rd_d = status;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q   <= '0;
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      rd_q   <= rd_d;
      ovr_q  <= ovr_d;
      ferr_q <= ferr_d;
    end
  end

  assign register_read_value = rd_q;
endmodule

// File: tb/tb_uart_registers.sv
// Randomized bench for uart_registers: queue models of both FIFOs,
// bit-accurate serial line checks and STATUS derived from model state.
module tb_uart_registers;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [6:0]  register_index = '0;
  logic        register_read = 1'b0;
  logic        register_write = 1'b0;
  logic [15:0] register_write_value = '0;
  logic [15:0] register_read_value;
  logic        uart_tx;
  logic        uart_rx = 1'b1;

  always #5 clk = ~clk;

  uart_registers #(
    .CLOCKS_PER_BIT (CPB),
    .FIFO_DEPTH     (DEPTH),
    .BASE_INDEX     (7'd0)
  ) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .register_index       (register_index),
    .register_read        (register_read),
    .register_write       (register_write),
    .register_write_value (register_write_value),
    .register_read_value  (register_read_value),
    .uart_tx              (uart_tx),
    .uart_rx              (uart_rx)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] rx_model[$];
  logic [7:0] tx_exp[$];
  bit m_ovr = 0;
  bit m_ferr = 0;

  function automatic logic [15:0] st(input bit rxv, input bit txr,
                                     input bit ovr, input bit fe,
                                     input bit busy);
    return {11'h0, busy, fe, ovr, txr, rxv};
  endfunction

  task automatic rd(input logic [6:0] idx, output logic [15:0] v);
    register_index = idx;
    register_read  = 1'b1;
    @(negedge clk);
    register_read  = 1'b0;
    v = register_read_value;
  endtask

  task automatic wr(input logic [6:0] idx, input logic [15:0] val);
    register_index       = idx;
    register_write       = 1'b1;
    register_write_value = val;
    @(negedge clk);
    register_write       = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input bit stop);
    for (int i = 0; i < 10; i++) begin
      uart_rx = (i == 0) ? 1'b0 : (i == 9) ? stop : b[i-1];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // expects frames starting at the current negedge, one sample per clk
  task automatic watch_tx(input int n);
    logic [7:0] b;
    logic e;
    for (int f = 0; f < n; f++) begin
      b = tx_exp.pop_front();
      for (int k = 0; k < 10; k++) begin
        e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
        for (int c = 0; c < CPB; c++) begin
          n_cmp++;
          if (uart_tx !== e) begin
            n_err++;
            $display("FAIL tx_line frame %0d byte %h bit %0d cyc %0d got %b want %b",
                     f, b, k, c, uart_tx, e);
          end
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic test_reset;
    logic [15:0] v, e;
    reset_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (uart_tx !== 1'b1 || register_read_value !== 16'h0) begin
        n_err++;
        $display("FAIL reset_outputs got tx=%b rv=%h want tx=1 rv=0000",
                 uart_tx, register_read_value);
      end
    end
    reset_n = 1'b1;
    @(negedge clk);
    rd(7'd1, v);
    e = st(0, 1, 0, 0, 0);
    n_cmp++;
    if (v !== e) begin
      n_err++;
      $display("FAIL reset_status got %h want %h", v, e);
    end
  endtask

  task automatic test_tx_single(input logic [7:0] b);
    logic [15:0] v, e, v2;
    tx_exp.push_back(b);
    wr(7'd0, {8'($urandom), b});
    n_cmp++;
    if (uart_tx !== 1'b1) begin
      n_err++;
      $display("FAIL tx_latency got %b want 1", uart_tx);
    end
    @(negedge clk);
    fork
      watch_tx(1);
      begin
        repeat (10) @(negedge clk);
        rd(7'd1, v2);
      end
    join
    e = st(0, 1, 0, 0, 1);
    n_cmp++;
    if (v2 !== e) begin
      n_err++;
      $display("FAIL tx_busy_mid got %h want %h", v2, e);
    end
    rd(7'd1, v);
    e = st(0, 1, 0, 0, 0);
    n_cmp++;
    if (v !== e) begin
      n_err++;
      $display("FAIL tx_idle_after got %h want %h", v, e);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] v, vf, e;
    logic [7:0] b;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          b = 8'($urandom);
          if (i < DEPTH + 1) tx_exp.push_back(b);
          wr(7'd0, {8'h0, b});
        end
        rd(7'd1, vf);
      end
      begin
        for (int i = 0; i < 2; i++) begin
          n_cmp++;
          if (uart_tx !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_pre cyc %0d got %b want 1", i, uart_tx);
          end
          @(negedge clk);
        end
        watch_tx(DEPTH + 1);
      end
    join
    e = st(0, 0, 0, 0, 1);
    n_cmp++;
    if (vf !== e) begin
      n_err++;
      $display("FAIL b2b_full got %h want %h", vf, e);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (uart_tx !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_dropped cyc %0d got %b want 1", i, uart_tx);
      end
      @(negedge clk);
    end
    rd(7'd1, v);
    e = st(0, 1, 0, 0, 0);
    n_cmp++;
    if (v !== e) begin
      n_err++;
      $display("FAIL b2b_status got %h want %h", v, e);
    end
  endtask

  task automatic test_rx_basic;
    logic [15:0] v, e;
    send_rx(8'h3C, 1'b1);
    rx_model.push_back(8'h3C);
    rd(7'd1, v);
    e = st(1, 1, 0, 0, 0);
    n_cmp++;
    if (v !== e) begin
      n_err++;
      $display("FAIL rx_status_full got %h want %h", v, e);
    end
    rd(7'd0, v);
    e = {8'h0, rx_model.pop_front()};
    n_cmp++;
    if (v !== e) begin
      n_err++;
      $display("FAIL rx_data got %h want %h", v, e);
    end
    rd(7'd1, v);
    e = st(0, 1, 0, 0, 0);
    n_cmp++;
    if (v !== e) begin
      n_err++;
      $display("FAIL rx_status_empty got %h want %h", v, e);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (register_read_value !== e) begin
      n_err++;
      $display("FAIL read_hold got %h want %h", register_read_value, e);
    end
  endtask

  task automatic test_rx_overrun;
    logic [15:0] v, e;
    logic [7:0] b;
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom);
      if (rx_model.size() < DEPTH) rx_model.push_back(b);
      else m_ovr = 1;
      send_rx(b, 1'b1);
    end
    wr(7'd9, 16'hFFFF);
    rd(7'd2, v);
    n_cmp++;
    if (v !== 16'h0) begin
      n_err++;
      $display("FAIL other_index got %h want 0000", v);
    end
    rd(7'd1, v);
    e = st(1, 1, m_ovr, m_ferr, 0);
    n_cmp++;
    if (v !== e) begin
      n_err++;
      $display("FAIL ovr_status got %h want %h", v, e);
    end
    wr(7'd1, 16'h0004);
    m_ovr = 0;
    rd(7'd1, v);
    e = st(1, 1, m_ovr, m_ferr, 0);
    n_cmp++;
    if (v !== e) begin
      n_err++;
      $display("FAIL ovr_clear got %h want %h", v, e);
    end
    while (rx_model.size() > 0) begin
      e = {8'h0, rx_model.pop_front()};
      rd(7'd0, v);
      n_cmp++;
      if (v !== e) begin
        n_err++;
        $display("FAIL ovr_data got %h want %h", v, e);
      end
    end
    rd(7'd0, v);
    n_cmp++;
    if (v !== 16'h0) begin
      n_err++;
      $display("FAIL empty_read got %h want 0000", v);
    end
  endtask

  task automatic test_frame_error;
    logic [15:0] v, e;
    send_rx(8'($urandom), 1'b0);
    m_ferr = 1;
    rd(7'd1, v);
    e = st(0, 1, m_ovr, m_ferr, 0);
    n_cmp++;
    if (v !== e) begin
      n_err++;
      $display("FAIL ferr_status got %h want %h", v, e);
    end
    wr(7'd1, 16'h0008);
    m_ferr = 0;
    rd(7'd1, v);
    e = st(0, 1, m_ovr, m_ferr, 0);
    n_cmp++;
    if (v !== e) begin
      n_err++;
      $display("FAIL ferr_clear got %h want %h", v, e);
    end
  endtask

  task automatic test_glitch;
    logic [15:0] v, e;
    logic [7:0] b;
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (8) @(negedge clk);
    rd(7'd1, v);
    e = st(0, 1, 0, 0, 0);
    n_cmp++;
    if (v !== e) begin
      n_err++;
      $display("FAIL glitch_status got %h want %h", v, e);
    end
    b = 8'($urandom);
    send_rx(b, 1'b1);
    rd(7'd0, v);
    n_cmp++;
    if (v !== {8'h0, b}) begin
      n_err++;
      $display("FAIL glitch_rearm got %h want %h", v, {8'h0, b});
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] v, vb, e;
    fork
      send_rx({4'hF, 4'($urandom)}, 1'b1);
      begin
        repeat (6) @(negedge clk);
        wr(7'd0, 16'h0000);
        repeat (10) @(negedge clk);
        rd(7'd1, vb);
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (uart_tx !== 1'b1 || register_read_value !== 16'h0) begin
          n_err++;
          $display("FAIL async_reset got tx=%b rv=%h want tx=1 rv=0000",
                   uart_tx, register_read_value);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
      end
    join
    e = st(0, 1, 0, 0, 1);
    n_cmp++;
    if (vb !== e) begin
      n_err++;
      $display("FAIL pre_reset_status got %h want %h", vb, e);
    end
    for (int i = 0; i < 10 * CPB; i++) begin
      n_cmp++;
      if (uart_tx !== 1'b1) begin
        n_err++;
        $display("FAIL tx_aborted cyc %0d got %b want 1", i, uart_tx);
      end
      @(negedge clk);
    end
    rd(7'd1, v);
    e = st(0, 1, 0, 0, 0);
    n_cmp++;
    if (v !== e) begin
      n_err++;
      $display("FAIL rx_aborted got %h want %h", v, e);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_tx_single(8'hA5);
    test_tx_single(8'($urandom));
    test_back_to_back();
    test_rx_basic();
    test_rx_overrun();
    test_frame_error();
    test_glitch();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
